// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
// FSM states and requester grant IDs, plus a grant-to-state mapping helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_e;

    function automatic arb_state_e busy_state(input grant_e gnt);
        arb_state_e st;
        case (gnt)
            GNT_IF:  st = IF_BUSY;
            GNT_DM:  st = DM_BUSY;
            default: st = IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// and on contention the requester that was not served last wins.
module rr_grant_picker
    import arb_pkg::*;
(
    input  logic   if_pending,
    input  logic   dm_pending,
    input  grant_e last_grant,
    output logic   grant_valid,
    output grant_e grant_id
);

    // Pick the winner from the pending pair and the previous grant
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = GNT_IF;
        case ({if_pending, dm_pending})
            2'b10: begin
                grant_valid = 1'b1;
                grant_id    = GNT_IF;
            end
            2'b01: begin
                grant_valid = 1'b1;
                grant_id    = GNT_DM;
            end
            2'b11: begin
                grant_valid = 1'b1;
                if (last_grant == GNT_IF) begin
                    grant_id = GNT_DM;
                end else begin
                    grant_id = GNT_IF;
                end
            end
            default: begin
                grant_valid = 1'b0;
                grant_id    = GNT_IF;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing memory port between instruction fetch and data memory
// requesters, with busywait stalls and a bounded wait that aborts hung accesses.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IF_READ,
    input  logic [ADDR_W-1:0] IF_ADDRESS,
    output logic [DATA_W-1:0] IF_READDATA,
    output logic              IF_BUSYWAIT,
    input  logic              DM_READ,
    input  logic              DM_WRITE,
    input  logic [ADDR_W-1:0] DM_ADDRESS,
    input  logic [DATA_W-1:0] DM_WRITEDATA,
    output logic [DATA_W-1:0] DM_READDATA,
    output logic              DM_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              TIMEOUT
);

    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    grant_e            last_grant_r;
    grant_e            pick_id_s;
    logic              pick_valid_s;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              timeout_r;

    logic              dm_pending_s;
    logic              busy_s;
    logic              abort_s;
    logic              done_s;
    logic              grant_s;
    logic              if_done_s;
    logic              dm_done_s;
    logic              dm_rd_done_s;
    logic [DATA_W-1:0] resp_data_s;

    assign dm_pending_s = DM_READ | DM_WRITE;
    assign busy_s       = (state_r == IF_BUSY) || (state_r == DM_BUSY);
    // An abort is treated exactly like a completion, returning all ones
    assign abort_s      = busy_s & MEM_BUSYWAIT & (wait_cnt_r == WAIT_LAST);
    assign done_s       = busy_s & (~MEM_BUSYWAIT | abort_s);
    assign grant_s      = (state_r == IDLE) & pick_valid_s;
    assign if_done_s    = done_s & (state_r == IF_BUSY);
    assign dm_done_s    = done_s & (state_r == DM_BUSY);
    assign dm_rd_done_s = dm_done_s & ~mem_write_r;
    assign resp_data_s  = abort_s ? {DATA_W{1'b1}} : MEM_READDATA;

    rr_grant_picker u_picker (
        .if_pending  (IF_READ),
        .dm_pending  (dm_pending_s),
        .last_grant  (last_grant_r),
        .grant_valid (pick_valid_s),
        .grant_id    (pick_id_s)
    );

    // Next-state logic: grant only from IDLE, return to IDLE on completion
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s = busy_state(pick_id_s);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the granted request into the memory-side registers; drop strobes on completion
    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_grant_r <= GNT_IF;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
        end else if (grant_s) begin
            last_grant_r <= pick_id_s;
            if (pick_id_s == GNT_DM) begin
                mem_addr_r  <= DM_ADDRESS;
                mem_wdata_r <= DM_WRITEDATA;
                mem_write_r <= DM_WRITE;
                mem_read_r  <= ~DM_WRITE;
            end else begin
                mem_addr_r  <= IF_ADDRESS;
                mem_write_r <= 1'b0;
                mem_read_r  <= 1'b1;
            end
        end else if (done_s) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end
    end

    // Wait counter: cleared on grant, counts every non-completing busy cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_s) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (busy_s && !done_s) begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
        end
    end

    // Per-port readdata latches and the sticky abort flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if_rdata_r <= {DATA_W{1'b0}};
            dm_rdata_r <= {DATA_W{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            if (if_done_s) begin
                if_rdata_r <= resp_data_s;
            end
            if (dm_rd_done_s) begin
                dm_rdata_r <= resp_data_s;
            end
            if (abort_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign IF_BUSYWAIT   = IF_READ & ~if_done_s;
    assign DM_BUSYWAIT   = dm_pending_s & ~dm_done_s;
    assign IF_READDATA   = if_done_s ? resp_data_s : if_rdata_r;
    assign DM_READDATA   = dm_rd_done_s ? resp_data_s : dm_rdata_r;
    assign MEM_READ      = mem_read_r;
    assign MEM_WRITE     = mem_write_r;
    assign MEM_ADDRESS   = mem_addr_r;
    assign MEM_WRITEDATA = mem_wdata_r;
    assign TIMEOUT       = timeout_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural memory
// of configurable latency and an expected-transaction scoreboard.
module tb_mem_port_arbiter;

    localparam int TB_MAX_WAIT = 8;

    logic        CLK;
    logic        RESET;
    logic        IF_READ;
    logic [9:0]  IF_ADDRESS;
    logic [31:0] IF_READDATA;
    logic        IF_BUSYWAIT;
    logic        DM_READ;
    logic        DM_WRITE;
    logic [9:0]  DM_ADDRESS;
    logic [31:0] DM_WRITEDATA;
    logic [31:0] DM_READDATA;
    logic        DM_BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [9:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
    logic        TIMEOUT;

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(TB_MAX_WAIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .IF_READ(IF_READ), .IF_ADDRESS(IF_ADDRESS), .IF_READDATA(IF_READDATA), .IF_BUSYWAIT(IF_BUSYWAIT),
        .DM_READ(DM_READ), .DM_WRITE(DM_WRITE), .DM_ADDRESS(DM_ADDRESS), .DM_WRITEDATA(DM_WRITEDATA),
        .DM_READDATA(DM_READDATA), .DM_BUSYWAIT(DM_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT), .TIMEOUT(TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input int a);
        return 32'h1000_0000 ^ (a * 32'h0001_0101);
    endfunction

    // Behavioural memory: busy for lat-1 strobe cycles, or forever while hang is set
    logic [31:0] mem_model [0:1023];
    int          lat;
    logic        hang;
    int          acc_cnt;

    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) & (hang | (acc_cnt < lat - 1));
    assign MEM_READDATA = MEM_BUSYWAIT ? 32'hDEAD_BEEF : mem_model[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 1024; i++) mem_model[i] <= init_word(i);
            acc_cnt <= 0;
        end else begin
            if ((MEM_READ | MEM_WRITE) & MEM_BUSYWAIT) acc_cnt <= acc_cnt + 1;
            else acc_cnt <= 0;
            if (MEM_WRITE & ~MEM_BUSYWAIT) mem_model[MEM_ADDRESS] <= MEM_WRITEDATA;
        end
    end

    typedef struct {
        logic        dm;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        hang;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_if_rd;
    logic [31:0] exp_dm_rd;
    logic [31:0] exp_timeout;
    int          n_asserts;
    int          n_fail;
    int          last_k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic dm, input logic wr, input logic [9:0] addr, input logic [31:0] wd);
        exp_t e;
        e.dm = dm; e.wr = wr; e.addr = addr; e.wd = wd; e.hang = 1'b0;
        if (wr) begin
            ref_mem[addr] = wd;
            e.rd = exp_dm_rd;
        end else begin
            e.rd = ref_mem[addr];
            if (dm) exp_dm_rd = e.rd;
            else exp_if_rd = e.rd;
        end
        sb_q.push_back(e);
    endtask

    task automatic push_hang_read(input logic [9:0] addr);
        exp_t e;
        e.dm = 1'b1; e.wr = 1'b0; e.addr = addr; e.wd = 32'h0; e.hang = 1'b1;
        e.rd = 32'hFFFF_FFFF;
        exp_dm_rd = e.rd;
        sb_q.push_back(e);
    endtask

    // Watch the memory port cycle by cycle and retire expected transactions as they complete
    task automatic sb_drain(input int n, input int budget);
        int          done_cnt;
        int          k;
        int          cyc;
        exp_t        e;
        logic        own_bw;
        logic        own_req;
        logic        oth_bw;
        logic        oth_req;
        logic [31:0] own_rd;
        done_cnt = 0; k = 0; cyc = 0;
        while (done_cnt < n && cyc < budget) begin
            @(negedge CLK); cyc++;
            if (MEM_READ || MEM_WRITE) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_strobe", sb_q.size(), 32'd1);
                end else begin
                    e = sb_q[0]; k++;
                    own_bw  = e.dm ? DM_BUSYWAIT : IF_BUSYWAIT;
                    own_req = e.dm ? (DM_READ | DM_WRITE) : IF_READ;
                    oth_bw  = e.dm ? IF_BUSYWAIT : DM_BUSYWAIT;
                    oth_req = e.dm ? IF_READ : (DM_READ | DM_WRITE);
                    own_rd  = e.dm ? DM_READDATA : IF_READDATA;
                    chk("mem_addr", MEM_ADDRESS, e.addr);
                    chk("mem_write", MEM_WRITE, e.wr ? 32'd1 : 32'd0);
                    chk("mem_read", MEM_READ, e.wr ? 32'd0 : 32'd1);
                    if (e.wr) chk("mem_wdata", MEM_WRITEDATA, e.wd);
                    if (!MEM_BUSYWAIT || (e.hang && k == TB_MAX_WAIT)) begin
                        chk("own_busywait_done", own_bw, 32'd0);
                        chk("other_busywait", oth_bw, oth_req);
                        chk("readdata_done", own_rd, e.rd);
                        chk("timeout_at_done", TIMEOUT, exp_timeout);
                        void'(sb_q.pop_front());
                        done_cnt++; last_k = k; k = 0;
                        if (e.hang) exp_timeout = 32'd1;
                        @(negedge CLK); cyc++;
                        chk("idle_gap", MEM_READ | MEM_WRITE, 32'd0);
                        own_rd = e.dm ? DM_READDATA : IF_READDATA;
                        chk("readdata_latched", own_rd, e.rd);
                        chk("timeout_after", TIMEOUT, exp_timeout);
                    end else begin
                        chk("own_busywait_wait", own_bw, own_req);
                    end
                end
            end
        end
        chk("sb_completions", done_cnt, n);
    endtask

    initial begin
        n_asserts = 0; n_fail = 0; last_k = 0;
        exp_if_rd = 32'h0; exp_dm_rd = 32'h0; exp_timeout = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        lat = 3; hang = 1'b0;
        RESET = 1'b1;
        IF_READ = 1'b0; IF_ADDRESS = 10'd0;
        DM_READ = 1'b0; DM_WRITE = 1'b0; DM_ADDRESS = 10'd0; DM_WRITEDATA = 32'h0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_mem_read", MEM_READ, 32'd0);
        chk("rst_mem_write", MEM_WRITE, 32'd0);
        chk("rst_mem_addr", MEM_ADDRESS, 32'd0);
        chk("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
        chk("rst_if_rdata", IF_READDATA, 32'd0);
        chk("rst_dm_rdata", DM_READDATA, 32'd0);
        chk("rst_timeout", TIMEOUT, 32'd0);
        chk("rst_if_bw", IF_BUSYWAIT, 32'd0);
        chk("rst_dm_bw", DM_BUSYWAIT, 32'd0);

        // Single fetch, memory latency 3
        @(posedge CLK); #1;
        RESET = 1'b0;
        IF_READ = 1'b1; IF_ADDRESS = 10'd5;
        push_req(1'b0, 1'b0, 10'd5, 32'h0);
        @(negedge CLK);
        chk("c0_mem_read", MEM_READ, 32'd0);
        chk("c0_if_bw", IF_BUSYWAIT, 32'd1);
        sb_drain(1, 20);
        chk("if_latency", last_k, 32'd3);
        chk("if_rdata_5", IF_READDATA, init_word(5));
        IF_READ = 1'b0;

        // Contention held high: DM, IF, DM, IF
        lat = 2;
        IF_READ = 1'b1; IF_ADDRESS = 10'd30;
        DM_READ = 1'b1; DM_ADDRESS = 10'd20;
        push_req(1'b1, 1'b0, 10'd20, 32'h0);
        push_req(1'b0, 1'b0, 10'd30, 32'h0);
        push_req(1'b1, 1'b0, 10'd20, 32'h0);
        push_req(1'b0, 1'b0, 10'd30, 32'h0);
        sb_drain(4, 60);
        IF_READ = 1'b0; DM_READ = 1'b0;

        // Write with requester address/data changed mid-access
        lat = 3;
        DM_WRITE = 1'b1; DM_ADDRESS = 10'd9; DM_WRITEDATA = 32'h0000_00A5;
        push_req(1'b1, 1'b1, 10'd9, 32'h0000_00A5);
        @(posedge CLK); #1;
        DM_ADDRESS = 10'd3; DM_WRITEDATA = 32'h0000_00FF;
        sb_drain(1, 20);
        DM_WRITE = 1'b0;
        chk("mem9_written", mem_model[9], 32'h0000_00A5);
        chk("mem3_untouched", mem_model[3], init_word(3));

        // Read and write together perform a write; read it back
        DM_READ = 1'b1; DM_WRITE = 1'b1; DM_ADDRESS = 10'd4; DM_WRITEDATA = 32'd7;
        push_req(1'b1, 1'b1, 10'd4, 32'd7);
        sb_drain(1, 20);
        DM_WRITE = 1'b0;
        push_req(1'b1, 1'b0, 10'd4, 32'h0);
        sb_drain(1, 20);
        DM_READ = 1'b0;
        chk("dm_readback_4", DM_READDATA, 32'd7);

        // Fetch request dropped right after grant still completes
        IF_READ = 1'b1; IF_ADDRESS = 10'd12;
        push_req(1'b0, 1'b0, 10'd12, 32'h0);
        @(posedge CLK); #1;
        IF_READ = 1'b0;
        sb_drain(1, 20);
        chk("if_rdata_12", IF_READDATA, init_word(12));

        // Hung memory is aborted after MAX_WAIT cycles
        hang = 1'b1;
        DM_READ = 1'b1; DM_ADDRESS = 10'd7;
        push_hang_read(10'd7);
        sb_drain(1, 30);
        DM_READ = 1'b0; hang = 1'b0;
        chk("abort_cycle", last_k, TB_MAX_WAIT);
        chk("timeout_set", TIMEOUT, 32'd1);
        IF_READ = 1'b1; IF_ADDRESS = 10'd6;
        push_req(1'b0, 1'b0, 10'd6, 32'h0);
        sb_drain(1, 20);
        IF_READ = 1'b0;
        chk("timeout_sticky", TIMEOUT, 32'd1);

        // Reset in the second cycle of a DM read
        lat = 5;
        DM_READ = 1'b1; DM_ADDRESS = 10'd20;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rr_c1_strobe", MEM_READ, 32'd1);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        chk("rr_c2_dm_bw", DM_BUSYWAIT, 32'd1);
        @(posedge CLK); #1;
        RESET = 1'b0; DM_READ = 1'b0;
        @(negedge CLK);
        chk("rr_mem_read", MEM_READ, 32'd0);
        chk("rr_mem_write", MEM_WRITE, 32'd0);
        chk("rr_mem_addr", MEM_ADDRESS, 32'd0);
        chk("rr_dm_rdata", DM_READDATA, 32'd0);
        chk("rr_if_rdata", IF_READDATA, 32'd0);
        chk("rr_timeout", TIMEOUT, 32'd0);
        repeat (3) @(negedge CLK);
        chk("rr_stays_idle", MEM_READ | MEM_WRITE, 32'd0);
        chk("rr_sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
